// File: rtl/dmem_pkg.sv
// Shared types and address-geometry helpers for the data-memory responder.
// Build option: DMEM_STATS_EN adds request statistics counters to dmem_responder.
package dmem_pkg;

    localparam int DEF_REG_WIDTH  = 32;
    localparam int DEF_LINE_WIDTH = 2;
    localparam int DEF_PA_WIDTH   = 32;
    localparam int DEF_MEM_LINES  = 64;
    localparam int DEF_LATENCY    = 4;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    typedef logic [DEF_LINE_WIDTH*DEF_REG_WIDTH-1:0] line_t;

    // Byte-offset bits inside one line.
    function automatic int off_w(input int reg_width, input int line_width);
        return $clog2(line_width * reg_width / 8);
    endfunction

    function automatic int idx_w(input int mem_lines);
        return $clog2(mem_lines);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Line-wide backing storage: synchronous write, asynchronous read.
module dmem_array #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 64,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: storage arrays carry no reset; clearing them would turn the RAM into a flop bank.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the data cache: one outstanding line read/write, fixed latency.
// Build option: DMEM_STATS_EN adds o_n_reads / o_n_writes saturating request counters.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int REG_WIDTH  = DEF_REG_WIDTH,
    parameter int PA_WIDTH   = DEF_PA_WIDTH,
    parameter int LINE_WIDTH = DEF_LINE_WIDTH,
    parameter int MEM_LINES  = DEF_MEM_LINES,
    parameter int LATENCY    = DEF_LATENCY
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_req_valid,
    output logic                            o_req_ready,
    input  logic                            i_req_write,
    input  logic [PA_WIDTH-1:0]             i_req_addr,
    input  logic [LINE_WIDTH*REG_WIDTH-1:0] i_req_wdata,
    output logic                            o_resp_valid,
    input  logic                            i_resp_ready,
    output logic [LINE_WIDTH*REG_WIDTH-1:0] o_resp_rdata,
    output logic                            o_resp_exeption
`ifdef DMEM_STATS_EN
   ,output logic [15:0]                     o_n_reads,
    output logic [15:0]                     o_n_writes
`endif
);

    localparam int DATA_W = LINE_WIDTH * REG_WIDTH;
    localparam int OFF    = off_w(REG_WIDTH, LINE_WIDTH);
    localparam int IDX    = idx_w(MEM_LINES);
    localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               req_write;
    logic               req_exc;
    logic [IDX-1:0]     req_idx;
    logic [DATA_W-1:0]  req_wdata;
    logic [DATA_W-1:0]  rd_line;
    logic               mem_we;
    logic               addr_exc;
    logic               unused_offset_bits;

    // Any address bit above the indexed range makes the request fall outside the array.
    assign addr_exc           = |(i_req_addr >> (OFF + IDX));
    assign unused_offset_bits = ^i_req_addr[OFF-1:0];

    // The write commits on the same edge that enters RESP, so a reset before then drops it.
    assign mem_we = (state == BUSY) && (cnt == '0) && req_write && !req_exc;

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (MEM_LINES),
        .IDX_W  (IDX)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (req_idx),
        .wdata (req_wdata),
        .rdata (rd_line)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            cnt             <= '0;
            req_write       <= 1'b0;
            req_exc         <= 1'b0;
            req_idx         <= '0;
            req_wdata       <= '0;
            o_req_ready     <= 1'b1;
            o_resp_valid    <= 1'b0;
            o_resp_rdata    <= '0;
            o_resp_exeption <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req_valid) begin
                        req_write   <= i_req_write;
                        req_exc     <= addr_exc;
                        req_idx     <= i_req_addr[OFF +: IDX];
                        req_wdata   <= i_req_wdata;
                        cnt         <= CNT_W'(LATENCY - 1);
                        o_req_ready <= 1'b0;
                        // With LATENCY==1 the counter starts at zero and BUSY lasts one edge.
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state           <= RESP;
                        o_resp_valid    <= 1'b1;
                        o_resp_exeption <= req_exc;
                        o_resp_rdata    <= (req_write || req_exc) ? '0 : rd_line;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (i_resp_ready) begin
                        state           <= IDLE;
                        o_req_ready     <= 1'b1;
                        o_resp_valid    <= 1'b0;
                        o_resp_rdata    <= '0;
                        o_resp_exeption <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    o_req_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef DMEM_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_n_reads  <= '0;
            o_n_writes <= '0;
        end else if (state == IDLE && i_req_valid) begin
            if (i_req_write) begin
                if (o_n_writes != 16'hFFFF) o_n_writes <= o_n_writes + 16'd1;
            end else begin
                if (o_n_reads != 16'hFFFF) o_n_reads <= o_n_reads + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder (default geometry, LATENCY=4).
// Build option: DMEM_STATS_EN also checks the request counters.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int LAT = 4;

    typedef struct {
        line_t rdata;
        logic  exc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_req_write = 1'b0;
    logic [31:0] i_req_addr = '0;
    line_t       i_req_wdata = '0;
    logic        o_resp_valid;
    logic        i_resp_ready = 1'b0;
    line_t       o_resp_rdata;
    logic        o_resp_exeption;
`ifdef DMEM_STATS_EN
    logic [15:0] o_n_reads;
    logic [15:0] o_n_writes;
`endif

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_reads = 0;
    int   exp_writes = 0;

    localparam line_t L0  = 64'hDEAD_0000_BEEF_0000;
    localparam line_t L1  = {32'd4, 32'd2};
    localparam line_t L3  = 64'hA5A5_0003_3C3C_0003;
    localparam line_t L63 = 64'h6363_6363_0F0F_003F;
    localparam line_t W79 = {32'd7, 32'd9};

    always #5 clk = ~clk;

    dmem_responder dut (
        .clk             (clk),
        .rst             (rst),
        .i_req_valid     (i_req_valid),
        .o_req_ready     (o_req_ready),
        .i_req_write     (i_req_write),
        .i_req_addr      (i_req_addr),
        .i_req_wdata     (i_req_wdata),
        .o_resp_valid    (o_resp_valid),
        .i_resp_ready    (i_resp_ready),
        .o_resp_rdata    (o_resp_rdata),
        .o_resp_exeption (o_resp_exeption)
`ifdef DMEM_STATS_EN
       ,.o_n_reads       (o_n_reads),
        .o_n_writes      (o_n_writes)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_stats(input string tag);
`ifdef DMEM_STATS_EN
        check({tag, "_reads"}, 64'(o_n_reads), 64'(exp_reads));
        check({tag, "_writes"}, 64'(o_n_writes), 64'(exp_writes));
`endif
    endtask

    // Present one request for a single edge; keep=1 leaves a spurious write asserted while busy.
    task automatic issue(input logic wr, input logic [31:0] addr, input line_t wd,
                         input line_t exp_rd, input logic exp_exc, input logic keep);
        exp_t e;
        check("ready_idle", 64'(o_req_ready), 64'd1);
        i_req_valid = 1'b1;
        i_req_write = wr;
        i_req_addr  = addr;
        i_req_wdata = wd;
        @(posedge clk); #1;
        e.rdata = exp_rd;
        e.exc   = exp_exc;
        sb.push_back(e);
        if (wr) exp_writes++; else exp_reads++;
        if (keep) begin
            i_req_write = 1'b1;
            i_req_addr  = 32'h18;
            i_req_wdata = 64'hBAD0_BAD0_BAD0_BAD0;
        end else begin
            i_req_valid = 1'b0;
            i_req_write = 1'b0;
            i_req_wdata = '0;
        end
        check("ready_accepted", 64'(o_req_ready), 64'd0);
    endtask

    // Check exact latency, pop the scoreboard, hold backpressure, then consume.
    task automatic collect(input int hold, input logic early_ready);
        exp_t e;
        i_resp_ready = early_ready;
        for (int c = 1; c < LAT; c++) begin
            @(posedge clk); #1;
            check("valid_early", 64'(o_resp_valid), 64'd0);
            check("ready_busy", 64'(o_req_ready), 64'd0);
        end
        @(posedge clk); #1;
        check("valid_at_latency", 64'(o_resp_valid), 64'd1);
        for (int c = 0; c < 16 && !o_resp_valid; c++) begin
            @(posedge clk); #1;
        end
        if (!o_resp_valid) check("resp_timeout", 64'(o_resp_valid), 64'd1);
        e = sb.pop_front();
        check("rdata", o_resp_rdata, e.rdata);
        check("exeption", 64'(o_resp_exeption), 64'(e.exc));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("hold_valid", 64'(o_resp_valid), 64'd1);
            check("hold_rdata", o_resp_rdata, e.rdata);
            check("hold_exeption", 64'(o_resp_exeption), 64'(e.exc));
            check("hold_req_ready", 64'(o_req_ready), 64'd0);
        end
        i_req_valid  = 1'b0;
        i_req_write  = 1'b0;
        i_resp_ready = 1'b1;
        @(posedge clk); #1;
        i_resp_ready = 1'b0;
        check("valid_cleared", 64'(o_resp_valid), 64'd0);
        check("ready_restored", 64'(o_req_ready), 64'd1);
    endtask

    initial begin
        dut.u_array.mem[0]  = L0;
        dut.u_array.mem[1]  = L1;
        dut.u_array.mem[3]  = L3;
        dut.u_array.mem[63] = L63;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(o_req_ready), 64'd1);
        check("rst_resp_valid", 64'(o_resp_valid), 64'd0);
        check("rst_rdata", o_resp_rdata, 64'd0);
        check("rst_exeption", 64'(o_resp_exeption), 64'd0);
        check_stats("rst_stats");
        rst = 1'b1;
        @(posedge clk); #1;

        issue(1'b0, 32'h8, '0, 64'h0000_0004_0000_0002, 1'b0, 1'b0);
        collect(0, 1'b1);
        issue(1'b0, 32'hC, '0, L1, 1'b0, 1'b0);
        collect(2, 1'b0);
        issue(1'b1, 32'h10, W79, '0, 1'b0, 1'b0);
        collect(0, 1'b0);
        issue(1'b0, 32'h10, '0, W79, 1'b0, 1'b1);
        collect(5, 1'b0);
        issue(1'b0, 32'h1F8, '0, L63, 1'b0, 1'b0);
        collect(1, 1'b0);
        issue(1'b0, 32'h200, '0, '0, 1'b1, 1'b0);
        collect(0, 1'b0);
        issue(1'b1, 32'h200, 64'h1111_2222_3333_4444, '0, 1'b1, 1'b0);
        collect(0, 1'b0);
        check("exc_write_line0", dut.u_array.mem[0], L0);
        check("ignored_req_line3", dut.u_array.mem[3], L3);
        check_stats("run_stats");

        // Reset while a write to line 3 is still counting down.
        i_req_valid = 1'b1;
        i_req_write = 1'b1;
        i_req_addr  = 32'h18;
        i_req_wdata = 64'hFFFF_EEEE_DDDD_CCCC;
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        i_req_write = 1'b0;
        @(posedge clk); #1;
        check("midbusy_ready", 64'(o_req_ready), 64'd0);
        rst = 1'b0;
        #2;
        exp_reads  = 0;
        exp_writes = 0;
        check("midrst_req_ready", 64'(o_req_ready), 64'd1);
        check("midrst_valid", 64'(o_resp_valid), 64'd0);
        check("midrst_rdata", o_resp_rdata, 64'd0);
        check_stats("midrst_stats");
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (LAT + 2) @(posedge clk);
        #1;
        check("post_rst_valid", 64'(o_resp_valid), 64'd0);
        check("dropped_write_line3", dut.u_array.mem[3], L3);
        issue(1'b0, 32'h18, '0, L3, 1'b0, 1'b0);
        collect(0, 1'b0);
        check_stats("final_stats");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
